// File: rtl/register_dump_pkg.sv
// Shared constants and state codes for the register dump engine.
package register_dump_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_PRESENT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/register_dump_if.sv
// Register-file read port, output beat stream and control strobes of the
// register dump engine.
interface register_dump_if #(
    parameter int DATA_W = register_dump_pkg::DATA_W
);
    import register_dump_pkg::*;

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic [ADDR_W-1:0] outIndex;
    logic              outLast;
    logic              busy;
    logic              done;

    modport slave (
        input  start, abort, rdData, outReady,
        output rdAddr, outValid, outData, outIndex, outLast, busy, done
    );

    modport master (
        output start, abort, rdData, outReady,
        input  rdAddr, outValid, outData, outIndex, outLast, busy, done
    );

endinterface

// File: rtl/register_dump.sv
// Walks the register file through its rs1 read port and streams every register
// out as a valid/ready beat, one register per three cycles at full rate.
module register_dump #(
    parameter int NUM_REGS = register_dump_pkg::NUM_REGS,
    parameter int DATA_W   = register_dump_pkg::DATA_W,
    parameter int SKIP_X0  = 1
) (
    input  logic           clk,
    input  logic           reset,
    register_dump_if.slave bus
);
    import register_dump_pkg::*;

    localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] beat_index;
    logic              valid;
    logic              last;

    // The file registers rdData one edge after rdAddr, so ISSUE holds the
    // address for one edge and WAIT captures the returned word at its edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            data       <= '0;
            beat_index <= '0;
            valid      <= 1'b0;
            last       <= 1'b0;
        end else if (bus.abort) begin
            state <= ST_IDLE;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        index <= FIRST_IDX;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    data       <= bus.rdData;
                    beat_index <= index;
                    last       <= (index == LAST_IDX);
                    valid      <= 1'b1;
                    state      <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (bus.outReady) begin
                        valid <= 1'b0;
                        if (last) begin
                            state <= ST_DONE;
                        end else begin
                            index <= index + 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rdAddr   = index;
    assign bus.outValid = valid;
    assign bus.outData  = data;
    assign bus.outIndex = beat_index;
    assign bus.outLast  = last;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);

endmodule

// File: tb/tb_register_dump.sv
// Scoreboard bench for register_dump: expected beats are queued from the
// bench's register file at dump start and popped by an independent monitor.
module tb_register_dump;
    import register_dump_pkg::*;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    int          vectors = 0;
    int          miscompares = 0;
    beat_t       exp_q[$];
    logic [31:0] rf[32];
    int          cyc = 0;
    int          beats = 0;
    int          done_cnt = 0;
    int          last_hs_edge = 0;
    logic        ready_mode = 1'b0;
    logic        ready_manual = 1'b1;
    logic        ready_rand = 1'b1;

    register_dump_if #(.DATA_W(32)) bus();

    assign bus.outReady = ready_mode ? ready_rand : ready_manual;

    register_dump #(.NUM_REGS(32), .DATA_W(32), .SKIP_X0(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rdData <= rf[bus.rdAddr];

    initial begin
        forever begin
            @(posedge clk);
            #1 ready_rand = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: a dump yields registers 1..31 in order, each carrying the
    // file contents, with last marking register 31.
    task automatic push_dump();
        for (int i = 1; i < 32; i++) begin
            beat_t b;
            b.idx  = 5'(i);
            b.data = rf[i];
            b.last = (i == 31);
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_rf();
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
    endtask

    task automatic start_dump(output int edge_no);
        push_dump();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        edge_no = cyc;
    endtask

    task automatic wait_beat(input logic [4:0] idx, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (bus.outValid && bus.outIndex == idx) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_beat_%0d: beat not presented, got none, required index %0d", idx, idx);
        end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        vectors++;
        if (done_cnt == d0) begin
            miscompares++;
            $display("FAIL done_timeout: got no done pulse, required one within 3000 cycles");
        end
    endtask

    task automatic finish_dump(input string name, input int b0, input int d0);
        wait_done(d0);
        check({name, "_beats"}, 64'(beats - b0), 64'd31);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: samples on the falling edge, pops on every accepted beat.
    initial begin
        bit          done_pend = 1'b0;
        bit          have_hold = 1'b0;
        logic [37:0] held = '0;
        beat_t       b;
        forever begin
            @(negedge clk);
            if (!reset) begin
                done_pend = 1'b0;
                have_hold = 1'b0;
            end else begin
                if (done_pend) begin
                    check("done_pulse", 64'(bus.done), 64'd1);
                    done_cnt++;
                    done_pend = 1'b0;
                end else if (bus.done) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1, required 0");
                end
                if (have_hold)
                    check("present_stable", 64'({bus.outValid, bus.outIndex, bus.outData, bus.outLast}),
                          64'({1'b1, held}));
                have_hold = bus.outValid && !bus.outReady && !bus.abort;
                held = {bus.outIndex, bus.outData, bus.outLast};
                if (bus.outValid && bus.outReady && !bus.abort) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got index %0d, required no beat", bus.outIndex);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat", 64'({bus.outIndex, bus.outData, bus.outLast}),
                              64'({b.idx, b.data, b.last}));
                    end
                    beats++;
                    last_hs_edge = cyc + 1;
                    if (bus.outLast) done_pend = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdAddr"}, 64'(bus.rdAddr), 64'd0);
        check({tag, "_outValid"}, 64'(bus.outValid), 64'd0);
        check({tag, "_outData"}, 64'(bus.outData), 64'd0);
        check({tag, "_outIndex"}, 64'(bus.outIndex), 64'd0);
        check({tag, "_outLast"}, 64'(bus.outLast), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int e0, b0, d0;
        bit ok;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Preset file, full-rate dump, latency of the whole scan.
        rf[1] = 32'd1;
        rf[29] = 32'd252;
        b0 = beats; d0 = done_cnt;
        start_dump(e0);
        finish_dump("preset", b0, d0);
        check("dump_span", 64'(last_hs_edge - e0), 64'd93);

        // Five cycles of back-pressure on the index-5 beat.
        rand_rf();
        b0 = beats; d0 = done_cnt;
        start_dump(e0);
        wait_beat(5'd5, ok);
        ready_manual = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(bus.outValid), 64'd1);
            check("stall_index", 64'(bus.outIndex), 64'd5);
            check("stall_data", 64'(bus.outData), 64'(rf[5]));
        end
        ready_manual = 1'b1;
        finish_dump("stall", b0, d0);

        // Abort while index 10 is presented, then a clean restart.
        rand_rf();
        d0 = done_cnt;
        start_dump(e0);
        wait_beat(5'd10, ok);
        bus.abort = 1'b1;
        ready_manual = 1'b0;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_valid", 64'(bus.outValid), 64'd0);
        exp_q.delete();
        ready_manual = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("abort_no_done", 64'(done_cnt), 64'(d0));
        b0 = beats;
        start_dump(e0);
        check("restart_rdAddr", 64'(bus.rdAddr), 64'd1);
        finish_dump("after_abort", b0, d0);

        // Start and abort together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of WAIT.
        rand_rf();
        start_dump(e0);
        @(posedge clk);
        #1 check("wait_busy", 64'(bus.busy), 64'd1);
        #1 reset = 1'b0;
        #1 check_reset_outputs("async");
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        b0 = beats; d0 = done_cnt;
        start_dump(e0);
        check("post_reset_rdAddr", 64'(bus.rdAddr), 64'd1);
        finish_dump("after_reset", b0, d0);

        // Start re-pulsed mid-dump is ignored.
        rand_rf();
        b0 = beats; d0 = done_cnt;
        start_dump(e0);
        wait_beat(5'd7, ok);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        finish_dump("restart_ignored", b0, d0);

        // Write to a not-yet-read register is visible in the dump.
        rand_rf();
        b0 = beats; d0 = done_cnt;
        start_dump(e0);
        wait_beat(5'd4, ok);
        rf[20] = 32'hDEADBEEF;
        foreach (exp_q[i]) if (exp_q[i].idx == 5'd20) exp_q[i].data = 32'hDEADBEEF;
        finish_dump("live_write", b0, d0);

        // Random contents under random back-pressure.
        ready_mode = 1'b1;
        repeat (2) begin
            rand_rf();
            b0 = beats; d0 = done_cnt;
            start_dump(e0);
            finish_dump("random", b0, d0);
        end
        ready_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion by 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
